// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide take one bit per cycle; a sign-fix state finishes the result.
module mult_div_unit (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic        isDiv;
  logic        signA;
  logic        signB;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] rsLatch;
  logic [63:0] acc;
  logic [4:0]  count;

  logic        signedOp;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic [32:0] divDiff;
  logic        divGe;
  logic [31:0] remNext;
  logic [63:0] accNext;
  logic [63:0] prodFix;
  logic [31:0] resHi;
  logic [31:0] resLo;

  // State register
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (count == 5'd31) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: depends on registered state only
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand magnitudes at launch
  always_comb begin
    signedOp = ~op[0];
    absA     = (signedOp && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    absB     = (signedOp && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
  end

  // One iteration step. Multiply: acc holds the running product, opA shifts the multiplier out
  // to the right. Divide: acc[63:32] is the partial remainder, acc[31:0] collects quotient bits,
  // and opA shifts the dividend out from the top.
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + (opA[0] ? {1'b0, opB} : 33'd0);
    divShift = {acc[63:32], opA[31]};
    divGe    = (divShift >= {1'b0, opB});
    divDiff  = divShift - {1'b0, opB};
    remNext  = divGe ? divDiff[31:0] : divShift[31:0];
    if (isDiv) accNext = {remNext, acc[30:0], divGe};
    else       accNext = {mulSum, acc[31:1]};
  end

  // Sign correction and special cases applied in FIX
  always_comb begin
    prodFix = (signA ^ signB) ? (~acc + 64'd1) : acc;
    resHi   = prodFix[63:32];
    resLo   = prodFix[31:0];
    if (isDiv) begin
      if (opB == 32'd0) begin
        resHi = rsLatch;
        resLo = '1;
      end else begin
        // Overflow case (-2^31 / -1) falls out naturally: magnitude 2^31 negates to itself.
        resLo = (signA ^ signB) ? (~acc[31:0] + 32'd1) : acc[31:0];
        resHi = signA ? (~acc[63:32] + 32'd1) : acc[63:32];
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      isDiv   <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      opA     <= '0;
      opB     <= '0;
      rsLatch <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv   <= op[1];
            signA   <= signedOp & rs_data[31];
            signB   <= signedOp & rt_data[31];
            opA     <= absA;
            opB     <= absB;
            rsLatch <= rs_data;
            acc     <= '0;
            count   <= '0;
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          acc   <= accNext;
          opA   <= isDiv ? (opA << 1) : (opA >> 1);
          count <= count + 5'd1;
        end
        FIX: begin
          hi   <= resHi;
          lo   <= resLo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative integer multiply/divide unit for the MIPS pipeline, in the EX stage directly downstream of the register file. It consumes the two register-file read operands for mult/multu/div/divu and holds the 64-bit result in internal HI/LO registers. mfhi/mflo read those registers; mthi/mtlo write them. While an operation is in flight, busy stalls the pipeline.

## Interface

Parameters:
- none (datapath fixed at 32 bits; iteration count fixed at 32)

Ports:
- Clk  in  1  clock; all state updates on posedge Clk
- reset  in  1  synchronous, active-high reset, sampled on posedge Clk
- start  in  1  launch operation selected by op; honoured only when idle
- op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- rs_data  in  32  operand A / dividend; also the data source for mthi/mtlo
- rt_data  in  32  operand B / divisor
- mthi  in  1  write rs_data into HI; honoured only when idle
- mtlo  in  1  write rs_data into LO; honoured only when idle
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  32  HI register (product high word / remainder)
- lo  out  32  LO register (product low word / quotient)

## Operation

- States:
  - IDLE: busy=0.
  - CALC: busy=1. 32 iterations, counter counts 0..31.
  - FIX: busy=1. Sign correction, then HI/LO write.
- IDLE with start=1:
  - Latch op.
  - For signed ops, latch |rs_data| and |rt_data| plus the two operand signs.
  - Clear the accumulator and counter.
  - Go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- Leave CALC for FIX when the counter reaches 31.
- FIX:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Write HI/LO, set done, return to IDLE.
- Divide by zero (rt_data=0), any signedness: LO=0xFFFFFFFF, HI=rs_data as latched. Full latency still applies.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0x00000000.
- mthi/mtlo in IDLE with start=0: the selected register takes rs_data at the edge. Both may be asserted together. done is not asserted.
- start together with mthi/mtlo in IDLE: start wins; mthi/mtlo are ignored.
- start, mthi or mtlo while busy=1: ignored, with no effect on state, operands, HI or LO.
- hi/lo hold their previous values throughout CALC; they update only at the FIX edge.

## Timing

- Reset values: state IDLE, busy=0, done=0, hi=0x00000000, lo=0x00000000, counter=0.
- Reset mid-operation: the operation is aborted. HI/LO clear and no done pulse is produced.
- reset has priority over every other input.
- Latency, with start sampled at edge N:
  - busy=1 in the cycles following edges N .. N+32 (33 cycles).
  - At edge N+33: busy=0, done=1, hi/lo show the result.
  - done drops at edge N+34 unless a new operation completes then.
- Back-to-back: start may be asserted in the same cycle done=1 (state is IDLE). The next result arrives 34 edges later.
- busy and done are registered outputs, with no combinational path from inputs.
- mthi/mtlo write latency: 1 edge.

## Test plan

- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> at edge N+33: HI=0xFFFFFFFE, LO=0x00000001, done for exactly 1 cycle, busy high for exactly 33 cycles.
- mult rs=0xFFFFFFFD (-3), rt=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Signed division:
  - div rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- divu rs=0x00000064, rt=0 -> LO=0xFFFFFFFF, HI=0x00000064.
- start with multu 3×4, then pulse start (op=divu) and mthi (rs=0xAAAAAAAA) at cycle 10 -> both ignored; result HI=0, LO=0x0000000C. Then mtlo rs=0x12345678 while idle -> LO=0x12345678 after 1 edge, no done.
- Reset mid-operation: start mult, assert reset at cycle 15 -> next edge busy=0, done=0, HI=LO=0. No done pulse ever appears for the aborted operation.
